display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter PRESCALE, default 50000, clock cycles per digit slot; SHALL be >= 4.
REQ-002 Parameter GUARD, default 16, blanking cycles at the start of each slot; SHALL satisfy 1 <= GUARD < PRESCALE.
REQ-003 Port clock  in  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  reset, asynchronous and active-high.
REQ-005 Port load  in  1  capture strobe; value_in is sampled on each rising edge where load=1.
REQ-006 Port value_in  in  16  four hex digits to display; digit i is value_in[4i+3:4i].
REQ-007 Port blank_en  in  1  leading-zero blanking enable, sampled every cycle.
REQ-008 Port nibble_out  out  4  nibble for the downstream 7-segment decoder.
REQ-009 Port digit_sel  out  4  active-low digit enables; bit i drives digit i.
REQ-010 Port blank_out  out  1  high when the current slot's digit is suppressed.

Function
REQ-011 Internal state SHALL consist of: shadow register (16), slot counter cnt (0..PRESCALE-1), digit index idx (0..3), FSM state {GUARD, ON}, and registered blank_en.
REQ-012 cnt SHALL increment every cycle and wrap from PRESCALE-1 to 0; on wrap, idx SHALL advance 0->1->2->3->0.
REQ-013 FSM SHALL be in GUARD while cnt < GUARD and in ON while cnt >= GUARD; GUARD->ON at cnt==GUARD-1, and ON->GUARD at the wrap.
REQ-014 In GUARD, digit_sel SHALL be 4'b1111.
REQ-015 In ON, digit_sel SHALL be ~(1<<idx), unless the digit is blanked (REQ-017), in which case it SHALL be 4'b1111.
REQ-016 nibble_out SHALL equal shadow[4*idx+3:4*idx] in both states.
REQ-017 Digit idx SHALL be blanked when registered blank_en=1, idx != 0, and every shadow nibble at positions >= idx is zero; digit 0 is never blanked.
REQ-018 blank_out SHALL be 1 exactly when the current digit is blanked, regardless of FSM state.
REQ-019 All outputs SHALL be driven from registers, with no combinational path from any input to any output.
REQ-020 Load latency: when load=1 at edge k, shadow SHALL hold value_in after edge k, and nibble_out/blank_out SHALL reflect the new value after edge k+1.
REQ-021 Load SHALL NOT disturb cnt, idx or the FSM state; back-to-back loads SHALL each capture, and the last one wins.
REQ-022 Load coinciding with a slot wrap SHALL apply both effects: the new digit shows the new value.
REQ-023 A change on blank_en SHALL take effect on outputs one cycle after it is sampled.

Reset
REQ-024 While reset=1, immediately and independent of clock: shadow=0, cnt=0, idx=0, FSM=GUARD, blank_en register=0, nibble_out=4'h0, digit_sel=4'b1111, blank_out=0.
REQ-025 Reset asserted mid-slot or mid-load SHALL discard the pending load; scanning SHALL restart at idx=0, cnt=0 on the first edge after release.

Structure
REQ-026 Shared package display_pkg SHALL hold NUM_DIGITS=4, DIGIT_OFF=4'b1111 and the scan state enum {GUARD, ON}.
REQ-027 The slot counter and wrap pulse SHALL be one sub-module, scan_tick, parameterised by PRESCALE; all other logic SHALL reside in display_scan.

Verification (PRESCALE=8, GUARD=2 unless noted)
REQ-028 Reset, then load 0x1234 with blank_en=0 -> in slots idx0..3 at cnt 2..7: digit_sel 1110/1101/1011/0111 with nibble_out 4/3/2/1; cnt 0..1 of each slot: digit_sel 1111.
REQ-029 blank_en=1, load 0x0050 -> idx3, idx2: digit_sel 1111, blank_out=1; idx1: digit_sel 1101, nibble 5; idx0: digit_sel 1110, nibble 0. Load 0x0000 -> only idx0 is lit.
REQ-030 Load 0xABCD at idx=0, cnt=7 -> next cycle idx=1, cnt=0, digit_sel 1111; at cnt=2: digit_sel 1101, nibble_out C.
REQ-031 Assert reset asynchronously at idx=2, cnt=5 (mid-clock) -> outputs reach their reset values before the next edge; after release, idx0 lights with nibble 0.
REQ-032 Loads on consecutive cycles 0x1111 then 0x2222 -> shadow=0x2222 and nibble_out=2 one cycle after the second load.
REQ-033 Defaults PRESCALE=50000, GUARD=16 -> the slot period measures exactly 50000 cycles, and digit_sel stays 1111 for exactly 16 cycles per slot.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed hex display scanner.
// Holds the digit count, the all-off digit enable pattern and the slot state.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    // SCAN_GUARD: blanking window at the start of a slot.
    // SCAN_ON:    the selected digit may be driven.
    typedef enum logic {
        SCAN_GUARD,
        SCAN_ON
    } scan_state_t;

endpackage

// File: rtl/scan_tick.sv
// Slot counter for the display scanner: counts 0..PRESCALE-1 and wraps.
// Ports: clock, reset (async, active-high), cnt (current count), wrap (cnt at last value).
module scan_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic [$clog2(PRESCALE)-1:0] cnt,
    output logic                        wrap
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    // High during the final cycle of a slot; the next edge starts a new slot.
    assign wrap = (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed hex display scanner with guard blanking and
// leading-zero suppression.
// Ports: clock, reset (async, active-high), load/value_in (capture strobe and
// 16-bit value), blank_en (leading-zero blanking), nibble_out (digit data),
// digit_sel (active-low digit enables), blank_out (current digit suppressed).
module display_scan
    import display_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic        blank_en,
    output logic [3:0]  nibble_out,
    output logic [3:0]  digit_sel,
    output logic        blank_out
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);

    logic [15:0]   shadow;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic [1:0]    idx;
    logic          blank_q;
    scan_state_t   state;

    logic [1:0]    idx_nx;
    scan_state_t   state_nx;
    logic [3:0]    nib_nx;
    logic          hi_zero;
    logic          blank_nx;
    logic [3:0]    sel_nx;

    scan_tick #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .cnt  (cnt),
        .wrap (wrap)
    );

    // Slot state tracks cnt: ON from cnt==GUARD through the wrap.
    always_comb begin
        state_nx = state;
        if (wrap) begin
            state_nx = SCAN_GUARD;
        end else if (cnt == G_LAST) begin
            state_nx = SCAN_ON;
        end
    end

    // Output registers are computed from the next slot position so that
    // digit_sel lines up with cnt, while data comes from the current shadow
    // and blank_en registers (one cycle behind their capture).
    always_comb begin
        idx_nx   = wrap ? idx + 2'd1 : idx;
        nib_nx   = shadow[{idx_nx, 2'b00} +: 4];
        hi_zero  = (shadow >> {idx_nx, 2'b00}) == 16'h0000;
        blank_nx = blank_q && (idx_nx != 2'd0) && hi_zero;
        sel_nx   = DIGIT_OFF;
        if (state_nx == SCAN_ON && !blank_nx) begin
            sel_nx = ~(4'b0001 << idx_nx);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow     <= 16'h0000;
            idx        <= 2'd0;
            state      <= SCAN_GUARD;
            blank_q    <= 1'b0;
            nibble_out <= 4'h0;
            digit_sel  <= DIGIT_OFF;
            blank_out  <= 1'b0;
        end else begin
            if (load) begin
                shadow <= value_in;
            end
            idx        <= idx_nx;
            state      <= state_nx;
            blank_q    <= blank_en;
            nibble_out <= nib_nx;
            digit_sel  <= sel_nx;
            blank_out  <= blank_nx;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Randomised self-checking bench for display_scan against a time-based model.
// Also measures slot period and guard length of a default-parameter instance.
module tb_display_scan;

    localparam int P = 8;
    localparam int G = 2;

    logic        clock;
    logic        reset;
    logic        load;
    logic [15:0] value_in;
    logic        blank_en;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_sel;
    logic        blank_out;

    logic        rst_d;
    logic        load_d;
    logic [15:0] val_d;
    logic        ben_d;
    logic [3:0]  nib_d;
    logic [3:0]  sel_d;
    logic        blk_d;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;
    bit meas_done = 0;

    // Model state: cycles since reset release, captured value, sampled blank_en.
    int          m_t;
    logic [15:0] m_shadow;
    logic        m_blank;
    logic [3:0]  e_nib;
    logic [3:0]  e_sel;
    logic        e_blk;
    int          m_cnt;
    int          m_idx;

    display_scan #(
        .PRESCALE(P),
        .GUARD   (G)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .value_in  (value_in),
        .blank_en  (blank_en),
        .nibble_out(nibble_out),
        .digit_sel (digit_sel),
        .blank_out (blank_out)
    );

    display_scan dut_def (
        .clock     (clock),
        .reset     (rst_d),
        .load      (load_d),
        .value_in  (val_d),
        .blank_en  (ben_d),
        .nibble_out(nib_d),
        .digit_sel (sel_d),
        .blank_out (blk_d)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position and displayed digit follow purely from elapsed cycles; the
    // data seen after an edge is what was captured before that edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_t      = 0;
            m_shadow = 16'h0;
            m_blank  = 1'b0;
            e_nib    = 4'h0;
            e_sel    = 4'b1111;
            e_blk    = 1'b0;
        end else begin
            m_t   = m_t + 1;
            m_cnt = m_t % P;
            m_idx = (m_t / P) % 4;
            e_nib = 4'((m_shadow >> (4 * m_idx)) & 16'hF);
            e_blk = m_blank && (m_idx != 0) && ((m_shadow >> (4 * m_idx)) == 0);
            e_sel = (m_cnt >= G && !e_blk) ? ~(4'b0001 << m_idx) : 4'b1111;
            if (load) m_shadow = value_in;
            m_blank = blank_en;
        end
        m_cnt = m_t % P;
        m_idx = (m_t / P) % 4;
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("nibble_out", int'(nibble_out), int'(e_nib));
            chk("digit_sel", int'(digit_sel), int'(e_sel));
            chk("blank_out", int'(blank_out), int'(e_blk));
        end
    end

    task automatic wait_pos(input int i, input int c);
        int n = 0;
        while (!(m_idx == i && m_cnt == c) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) chk("wait_pos_timeout", 1, 0);
    endtask

    task automatic pin(input string name, input logic [3:0] sel,
                       input logic [3:0] nib, input logic blk);
        chk({name, "_sel"}, int'(digit_sel), int'(sel));
        chk({name, "_nib"}, int'(nibble_out), int'(nib));
        chk({name, "_blk"}, int'(blank_out), int'(blk));
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 0) v[4*i +: 4] = 4'h0;
        return v;
    endfunction

    // Default-parameter instance: slot period and guard length.
    initial begin
        int cyc;
        int c1;
        int c2;
        int g;
        load_d = 1'b0;
        val_d  = 16'h0;
        ben_d  = 1'b0;
        rst_d  = 1'b0;
        #1 rst_d = 1'b1;
        #22 rst_d = 1'b0;
        cyc = 0;
        c1 = -1;
        c2 = -1;
        g = 0;
        while (sel_d == 4'b1111 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
        end
        c1 = cyc;
        while (sel_d != 4'b1111 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
        end
        while (sel_d == 4'b1111 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            g++;
        end
        c2 = cyc;
        chk("default_guard", g, 16);
        chk("default_period", c2 - c1, 50000);
        meas_done = 1;
    end

    initial begin
        load     = 1'b0;
        value_in = 16'h0;
        blank_en = 1'b0;
        reset    = 1'b0;
        #1 reset = 1'b1;
        @(negedge clock);
        pin("reset", 4'b1111, 4'h0, 1'b0);
        chk_en = 1;
        @(negedge clock);
        reset = 1'b0;

        @(negedge clock);
        load = 1'b1;
        value_in = 16'h1234;
        @(negedge clock);
        load = 1'b0;
        wait_pos(0, 5); pin("s0", 4'b1110, 4'h4, 1'b0);
        wait_pos(1, 1); pin("g1", 4'b1111, 4'h3, 1'b0);
        wait_pos(1, 5); pin("s1", 4'b1101, 4'h3, 1'b0);
        wait_pos(2, 0); pin("g2", 4'b1111, 4'h2, 1'b0);
        wait_pos(2, 7); pin("s2", 4'b1011, 4'h2, 1'b0);
        wait_pos(3, 2); pin("s3", 4'b0111, 4'h1, 1'b0);

        blank_en = 1'b1;
        load = 1'b1;
        value_in = 16'h0050;
        @(negedge clock);
        load = 1'b0;
        wait_pos(1, 5); pin("b1", 4'b1101, 4'h5, 1'b0);
        wait_pos(2, 5); pin("b2", 4'b1111, 4'h0, 1'b1);
        wait_pos(3, 5); pin("b3", 4'b1111, 4'h0, 1'b1);
        wait_pos(0, 5); pin("b0", 4'b1110, 4'h0, 1'b0);
        load = 1'b1;
        value_in = 16'h0000;
        @(negedge clock);
        load = 1'b0;
        wait_pos(1, 5); pin("z1", 4'b1111, 4'h0, 1'b1);
        wait_pos(3, 5); pin("z3", 4'b1111, 4'h0, 1'b1);
        wait_pos(0, 5); pin("z0", 4'b1110, 4'h0, 1'b0);

        wait_pos(0, 7);
        load = 1'b1;
        value_in = 16'hABCD;
        @(negedge clock);
        load = 1'b0;
        chk("wrap_guard_sel", int'(digit_sel), 4'b1111);
        wait_pos(1, 2); pin("wrap_new", 4'b1101, 4'hC, 1'b0);

        load = 1'b1;
        value_in = 16'h1111;
        @(negedge clock);
        value_in = 16'h2222;
        @(negedge clock);
        load = 1'b0;
        @(negedge clock);
        chk("b2b_nib", int'(nibble_out), 2);

        repeat (400) begin
            @(negedge clock);
            load = ($urandom_range(0, 3) == 0);
            value_in = rand_val();
            if ($urandom_range(0, 7) == 0) blank_en = ~blank_en;
        end

        @(negedge clock);
        load = 1'b0;
        blank_en = 1'b0;
        wait_pos(2, 5);
        load = 1'b1;
        value_in = 16'hFFFF;
        #2 reset = 1'b1;
        #1;
        pin("async_rst", 4'b1111, 4'h0, 1'b0);
        @(negedge clock);
        load = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wait_pos(0, 3); pin("post_rst", 4'b1110, 4'h0, 1'b0);
        wait_pos(1, 3); pin("post_rst1", 4'b1101, 4'h0, 1'b0);

        repeat (200) begin
            @(negedge clock);
            load = ($urandom_range(0, 2) == 0);
            value_in = rand_val();
            blank_en = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        load = 1'b0;
        chk_en = 0;

        wait (meas_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
